// File: rtl/instruction_sequencer.sv
// Instruction sequencer: queues host instructions and feeds them one at a
// time to instruction_processor, retiring each on the rising edge of done.
module instruction_sequencer #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 32,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_opcode,
  input  logic [4:0]    in_raddr1,
  input  logic [4:0]    in_raddr2,
  input  logic [4:0]    in_waddr,
  input  logic [15:0]   in_wdata,
  output logic [2:0]    opcode,
  output logic [4:0]    read_address1,
  output logic [4:0]    read_address2,
  output logic [4:0]    write_address,
  output logic [15:0]   write_data,
  input  logic          done,
  input  logic [15:0]   read_data1,
  input  logic [15:0]   read_data2,
  input  logic [15:0]   calculated_value,
  output logic          res_valid,
  output logic [2:0]    res_opcode,
  output logic [15:0]   res_rdata1,
  output logic [15:0]   res_rdata2,
  output logic [15:0]   res_value,
  output logic [CW-1:0] retired_count,
  output logic [AW:0]   fifo_level,
  output logic          busy,
  output logic          timeout_err
);

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  wa;
    logic [15:0] wd;
  } instr_t;

  typedef enum logic {IDLE, RUN} state_t;

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TMAX  = WW'(TIMEOUT);
  localparam logic [WW-1:0] TLAST = WW'(TIMEOUT - 1);
  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam instr_t        NOP   = {3'b001, 31'd0};

  state_t          r_state;
  state_t          w_state_nxt;
  instr_t          r_mem [DEPTH];
  instr_t          r_cur;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_level;
  logic            r_done_q;
  logic            r_res_valid;
  logic [2:0]      r_res_op;
  logic [15:0]     r_res_d1;
  logic [15:0]     r_res_d2;
  logic [15:0]     r_res_v;
  logic [CW-1:0]   r_count;
  logic [WW-1:0]   r_wait;
  logic            r_terr;

  logic   w_cmp;
  logic   w_empty;
  logic   w_full;
  logic   w_push;
  logic   w_pop;
  instr_t w_in;
  instr_t w_next;
  instr_t w_drv;

  assign w_cmp   = done & ~r_done_q;
  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == FULL);
  assign w_push  = in_valid & ~w_full;
  assign w_pop   = w_cmp & ~w_empty;
  assign w_in    = {in_opcode, in_raddr1, in_raddr2,
                    in_waddr, in_wdata};
  assign w_next  = w_empty ? NOP : r_mem[r_rptr];
  // On completion the next instruction is shown early so the processor
  // samples it at the same edge it restarts.
  assign w_drv   = w_cmp ? w_next : r_cur;

  assign opcode        = w_drv.op;
  assign read_address1 = w_drv.r1;
  assign read_address2 = w_drv.r2;
  assign write_address = w_drv.wa;
  assign write_data    = w_drv.wd;

  assign in_ready      = ~w_full;
  assign fifo_level    = r_level;
  assign busy          = (r_state == RUN);
  assign res_valid     = r_res_valid;
  assign res_opcode    = r_res_op;
  assign res_rdata1    = r_res_d1;
  assign res_rdata2    = r_res_d2;
  assign res_value     = r_res_v;
  assign retired_count = r_count;
  assign timeout_err   = r_terr;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_cmp && !w_empty) w_state_nxt = RUN;
      RUN:  if (w_cmp && w_empty)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_in;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cur       <= NOP;
      r_done_q    <= 1'b1;
      r_res_valid <= 1'b0;
      r_res_op    <= '0;
      r_res_d1    <= '0;
      r_res_d2    <= '0;
      r_res_v     <= '0;
      r_count     <= '0;
    end else begin
      r_done_q    <= done;
      r_res_valid <= w_cmp & busy;
      if (w_cmp) begin
        r_cur <= w_next;
        if (busy) begin
          r_res_op <= r_cur.op;
          r_res_d1 <= read_data1;
          r_res_d2 <= read_data2;
          r_res_v  <= calculated_value;
          r_count  <= r_count + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wait <= '0;
      r_terr <= 1'b0;
    end else if (w_cmp) begin
      r_wait <= '0;
    end else if (r_wait != TMAX) begin
      r_wait <= r_wait + 1'b1;
      if (r_wait == TLAST) r_terr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer with a behavioural processor
// stub (3/21-cycle latency, 32-entry register file, freezable).
module tb_instruction_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_opcode;
  logic [4:0]  in_raddr1, in_raddr2, in_waddr;
  logic [15:0] in_wdata;
  logic [2:0]  opcode;
  logic [4:0]  read_address1, read_address2, write_address;
  logic [15:0] write_data;
  logic        done;
  logic [15:0] read_data1, read_data2, calculated_value;
  logic        res_valid;
  logic [2:0]  res_opcode;
  logic [15:0] res_rdata1, res_rdata2, res_value;
  logic [7:0]  retired_count;
  logic [3:0]  fifo_level;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  logic hold;

  always #5 clk = ~clk;

  instruction_sequencer dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_raddr1(in_raddr1),
    .in_raddr2(in_raddr2), .in_waddr(in_waddr),
    .in_wdata(in_wdata),
    .opcode(opcode), .read_address1(read_address1),
    .read_address2(read_address2),
    .write_address(write_address), .write_data(write_data),
    .done(done), .read_data1(read_data1),
    .read_data2(read_data2),
    .calculated_value(calculated_value),
    .res_valid(res_valid), .res_opcode(res_opcode),
    .res_rdata1(res_rdata1), .res_rdata2(res_rdata2),
    .res_value(res_value), .retired_count(retired_count),
    .fifo_level(fifo_level), .busy(busy),
    .timeout_err(timeout_err)
  );

  // processor stub
  logic [15:0] regs [32];
  logic [4:0]  cyc;
  logic [2:0]  p_op;
  logic [4:0]  p_r1, p_r2, p_w;
  logic [15:0] p_wd;
  logic [15:0] p_val;
  logic [4:0]  p_lat;

  assign p_lat = (p_op >= 3'b101) ? 5'd21 : 5'd3;

  always_comb begin
    p_val = 16'h0;
    case (p_op)
      3'b000: p_val = p_wd;
      3'b010: p_val = regs[p_r1] & regs[p_r2];
      3'b011: p_val = regs[p_r1] | regs[p_r2];
      3'b100: p_val = regs[p_r1] ^ regs[p_r2];
      3'b101: p_val = regs[p_r1] + regs[p_r2];
      3'b110: p_val = regs[p_r1] - regs[p_r2];
      3'b111: p_val = regs[p_r1] << p_wd[3:0];
      default: p_val = 16'h0;
    endcase
  end

  always @(posedge clk) begin
    if (!rstn) begin
      cyc <= 5'd0;
      done <= 1'b0;
      p_op <= 3'b001;
      p_r1 <= 5'd0; p_r2 <= 5'd0; p_w <= 5'd0;
      p_wd <= 16'h0;
      read_data1 <= 16'h0;
      read_data2 <= 16'h0;
      calculated_value <= 16'h0;
      for (int i = 0; i < 32; i++) regs[i] <= 16'h0;
    end else if (!(hold && cyc != 5'd0)) begin
      if (cyc == 5'd0) begin
        p_op <= opcode;
        p_r1 <= read_address1;
        p_r2 <= read_address2;
        p_w  <= write_address;
        p_wd <= write_data;
        done <= 1'b0;
        cyc  <= 5'd1;
      end else if (cyc == p_lat) begin
        read_data1 <= regs[p_r1];
        read_data2 <= regs[p_r2];
        calculated_value <= p_val;
        if (p_op != 3'b001) regs[p_w] <= p_val;
        done <= 1'b1;
        cyc  <= 5'd0;
      end else begin
        cyc <= cyc + 5'd1;
      end
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [15:0] v;
  } res_t;
  res_t rq[$];

  always @(negedge clk) begin
    if (res_valid === 1'b1)
      rq.push_back('{res_opcode, res_rdata1, res_rdata2, res_value});
  end

  task automatic push(input logic [2:0] op, input logic [4:0] a1,
                      input logic [4:0] a2, input logic [4:0] w,
                      input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    in_opcode = op; in_raddr1 = a1; in_raddr2 = a2;
    in_waddr = w; in_wdata = d; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL push_wait in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_res(input int n, input int budget);
    int k = 0;
    while (rq.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (rq.size() < n) begin
      errors++;
      $display("FAIL wait_res got %0d required %0d", rq.size(), n);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle busy=%b required 0", busy);
    end
  endtask

  task automatic wait_busy();
    int k = 0;
    @(negedge clk);
    while (!busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_busy busy=%b required 1", busy);
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 7;
    if (opcode !== 3'b001) begin errors++;
      $display("FAIL rst_opcode got %b required 001", opcode); end
    if (fifo_level !== 4'd0) begin errors++;
      $display("FAIL rst_level got %0d required 0", fifo_level); end
    if (in_ready !== 1'b1) begin errors++;
      $display("FAIL rst_in_ready got %b required 1", in_ready); end
    if (busy !== 1'b0) begin errors++;
      $display("FAIL rst_busy got %b required 0", busy); end
    if (res_valid !== 1'b0) begin errors++;
      $display("FAIL rst_res_valid got %b required 0", res_valid); end
    if (retired_count !== 8'd0) begin errors++;
      $display("FAIL rst_count got %0d required 0", retired_count); end
    if (timeout_err !== 1'b0) begin errors++;
      $display("FAIL rst_terr got %b required 0", timeout_err); end
    rstn = 1'b1;
    rq.delete();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (opcode !== 3'b001 || write_address !== 5'd0) bad++;
    end
    checks += 4;
    if (bad != 0) begin errors++;
      $display("FAIL nop_outputs bad_cycles %0d required 0", bad); end
    if (rq.size() != 0) begin errors++;
      $display("FAIL nop_res got %0d required 0", rq.size()); end
    if (retired_count !== 8'd0) begin errors++;
      $display("FAIL nop_count got %0d required 0", retired_count); end
    if (timeout_err !== 1'b0) begin errors++;
      $display("FAIL nop_terr got %b required 0", timeout_err); end
  endtask

  task automatic test_write_add();
    rq.delete();
    push(3'b000, 5'd0, 5'd0, 5'd3, 16'h1234);
    push(3'b101, 5'd3, 5'd3, 5'd4, 16'h0000);
    wait_res(2, 200);
    checks += 7;
    if (rq[0].op !== 3'b000) begin errors++;
      $display("FAIL wa_op0 got %b required 000", rq[0].op); end
    if (rq[0].v !== 16'h1234) begin errors++;
      $display("FAIL wa_val0 got %h required 1234", rq[0].v); end
    if (rq[1].op !== 3'b101) begin errors++;
      $display("FAIL wa_op1 got %b required 101", rq[1].op); end
    if (rq[1].v !== 16'h2468) begin errors++;
      $display("FAIL wa_val1 got %h required 2468", rq[1].v); end
    if (rq[1].d1 !== 16'h1234) begin errors++;
      $display("FAIL wa_rd1 got %h required 1234", rq[1].d1); end
    if (rq[1].d2 !== 16'h1234) begin errors++;
      $display("FAIL wa_rd2 got %h required 1234", rq[1].d2); end
    if (retired_count !== 8'd2) begin errors++;
      $display("FAIL wa_count got %0d required 2", retired_count); end
  endtask

  task automatic test_sub_shift();
    rq.delete();
    push(3'b110, 5'd4, 5'd3, 5'd5, 16'h0000);
    push(3'b111, 5'd3, 5'd0, 5'd6, 16'h0001);
    wait_res(2, 200);
    checks += 6;
    if (rq[0].op !== 3'b110) begin errors++;
      $display("FAIL ss_op0 got %b required 110", rq[0].op); end
    if (rq[0].v !== 16'h1234) begin errors++;
      $display("FAIL ss_sub got %h required 1234", rq[0].v); end
    if (rq[0].d1 !== 16'h2468) begin errors++;
      $display("FAIL ss_r4 got %h required 2468", rq[0].d1); end
    if (rq[1].op !== 3'b111) begin errors++;
      $display("FAIL ss_op1 got %b required 111", rq[1].op); end
    if (rq[1].v !== 16'h2468) begin errors++;
      $display("FAIL ss_shl got %h required 2468", rq[1].v); end
    if (retired_count !== 8'd4) begin errors++;
      $display("FAIL ss_count got %0d required 4", retired_count); end
  endtask

  task automatic test_back_to_back();
    wait_idle();
    hold = 1'b1;
    rq.delete();
    for (int i = 0; i < 8; i++)
      push(3'b000, 5'd0, 5'd0, 5'(8 + i), 16'h00A0 + 16'(i));
    @(negedge clk);
    in_opcode = 3'b000; in_waddr = 5'd16; in_wdata = 16'h00A8;
    in_valid = 1'b1;
    checks += 2;
    if (fifo_level !== 4'd8) begin errors++;
      $display("FAIL b2b_full got %0d required 8", fifo_level); end
    if (in_ready !== 1'b0) begin errors++;
      $display("FAIL b2b_ready got %b required 0", in_ready); end
    @(negedge clk);
    checks++;
    if (fifo_level !== 4'd8) begin errors++;
      $display("FAIL b2b_ignored got %0d required 8", fifo_level); end
    in_valid = 1'b0;
    hold = 1'b0;
    push(3'b000, 5'd0, 5'd0, 5'd16, 16'h00A8);
    wait_res(9, 400);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (rq[i].v !== 16'h00A0 + 16'(i) || rq[i].op !== 3'b000) begin
        errors++;
        $display("FAIL b2b_order[%0d] got %h required %h",
                 i, rq[i].v, 16'h00A0 + 16'(i));
      end
    end
    checks += 2;
    if (retired_count !== 8'd13) begin errors++;
      $display("FAIL b2b_count got %0d required 13", retired_count); end
    if (timeout_err !== 1'b0) begin errors++;
      $display("FAIL b2b_terr got %b required 0", timeout_err); end
  endtask

  task automatic test_timeout();
    wait_idle();
    rq.delete();
    push(3'b000, 5'd0, 5'd0, 5'd9, 16'h5555);
    wait_busy();
    hold = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 31) begin
        checks++;
        if (timeout_err !== 1'b0) begin errors++;
          $display("FAIL to_early got %b required 0", timeout_err); end
      end
      if (k == 32) begin
        checks++;
        if (timeout_err !== 1'b1) begin errors++;
          $display("FAIL to_set got %b required 1", timeout_err); end
      end
    end
    hold = 1'b0;
    wait_res(1, 100);
    checks += 2;
    if (rq[0].v !== 16'h5555) begin errors++;
      $display("FAIL to_retire got %h required 5555", rq[0].v); end
    if (timeout_err !== 1'b1) begin errors++;
      $display("FAIL to_sticky got %b required 1", timeout_err); end
  endtask

  task automatic test_reset_mid();
    wait_idle();
    push(3'b101, 5'd3, 5'd3, 5'd10, 16'h0000);
    wait_busy();
    push(3'b000, 5'd0, 5'd0, 5'd11, 16'h0011);
    push(3'b000, 5'd0, 5'd0, 5'd12, 16'h0012);
    push(3'b000, 5'd0, 5'd0, 5'd13, 16'h0013);
    repeat (5) @(negedge clk);
    checks++;
    if (fifo_level !== 4'd3) begin errors++;
      $display("FAIL rm_pre got %0d required 3", fifo_level); end
    rstn = 1'b0;
    @(negedge clk);
    checks += 5;
    if (fifo_level !== 4'd0) begin errors++;
      $display("FAIL rm_level got %0d required 0", fifo_level); end
    if (busy !== 1'b0) begin errors++;
      $display("FAIL rm_busy got %b required 0", busy); end
    if (res_valid !== 1'b0) begin errors++;
      $display("FAIL rm_res_valid got %b required 0", res_valid); end
    if (timeout_err !== 1'b0) begin errors++;
      $display("FAIL rm_terr got %b required 0", timeout_err); end
    if (retired_count !== 8'd0) begin errors++;
      $display("FAIL rm_count got %0d required 0", retired_count); end
    rstn = 1'b1;
    rq.delete();
    repeat (60) @(negedge clk);
    checks += 2;
    if (rq.size() != 0) begin errors++;
      $display("FAIL rm_stale got %0d required 0", rq.size()); end
    if (retired_count !== 8'd0) begin errors++;
      $display("FAIL rm_count2 got %0d required 0", retired_count); end
  endtask

  initial begin
    rstn = 1'b0;
    hold = 1'b0;
    in_valid = 1'b0;
    in_opcode = 3'b000;
    in_raddr1 = 5'd0; in_raddr2 = 5'd0; in_waddr = 5'd0;
    in_wdata = 16'h0;
    test_reset();
    test_write_add();
    test_sub_shift();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
